// File: rtl/pipe_demux_32bit_1to2.sv
`default_nettype none
// ============================================================================
// Module   : pipe_demux_32bit_1to2
// Brief    : Registered 1-to-2 steering stage with per-output holding register
//            and per-output delivered-word counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_demux_32bit_1to2 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [WIDTH-1:0] out_a_data,
    output logic             out_b_valid,
    input  logic             out_b_ready,
    output logic [WIDTH-1:0] out_b_data,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam logic [CNT_W-1:0] c_cnt_one = 1;

    logic             r_a_valid;
    logic             r_b_valid;
    logic [WIDTH-1:0] r_a_data;
    logic [WIDTH-1:0] r_b_data;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    logic w_free_a;
    logic w_free_b;
    logic w_accept;
    logic w_load_a;
    logic w_load_b;
    logic w_deliv_a;
    logic w_deliv_b;

    // A register may refill in the same cycle it drains, giving 1 word/cycle.
    assign w_free_a  = !r_a_valid || out_a_ready;
    assign w_free_b  = !r_b_valid || out_b_ready;
    assign in_ready  = !flush && (in_sel ? w_free_b : w_free_a);
    assign w_accept  = in_valid && in_ready;
    assign w_load_a  = w_accept && !in_sel;
    assign w_load_b  = w_accept &&  in_sel;
    assign w_deliv_a = r_a_valid && out_a_ready;
    assign w_deliv_b = r_b_valid && out_b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
        end else if (flush) begin
            r_a_valid <= 1'b0;
        end else if (w_load_a) begin
            r_a_valid <= 1'b1;
            r_a_data  <= in_data;
        end else if (w_deliv_a) begin
            r_a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
        end else if (flush) begin
            r_b_valid <= 1'b0;
        end else if (w_load_b) begin
            r_b_valid <= 1'b1;
            r_b_data  <= in_data;
        end else if (w_deliv_b) begin
            r_b_valid <= 1'b0;
        end
    end

    // A handshake completed during a flush cycle is still a delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_deliv_a) r_cnt_a <= r_cnt_a + c_cnt_one;
            if (w_deliv_b) r_cnt_b <= r_cnt_b + c_cnt_one;
        end
    end

    assign out_a_valid = r_a_valid;
    assign out_a_data  = r_a_data;
    assign out_b_valid = r_b_valid;
    assign out_b_data  = r_b_data;
    assign cnt_a       = r_cnt_a;
    assign cnt_b       = r_cnt_b;

endmodule
`default_nettype wire

// File: tb/tb_pipe_demux_32bit_1to2.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_demux_32bit_1to2
// Brief    : Self-checking bench for pipe_demux_32bit_1to2 against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_demux_32bit_1to2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_sel = 1'b0;
    logic        out_a_valid;
    logic        out_a_ready = 1'b0;
    logic [31:0] out_a_data;
    logic        out_b_valid;
    logic        out_b_ready = 1'b0;
    logic [31:0] out_b_data;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    int total = 0;
    int bad   = 0;

    pipe_demux_32bit_1to2 #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_data(out_a_data),
        .out_b_valid(out_b_valid), .out_b_ready(out_b_ready), .out_b_data(out_b_data),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    always #5 clk = ~clk;

    // Reference: each output is a FIFO of capacity one; last-loaded word persists.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] last_a, last_b;
    int unsigned m_ca, m_cb;
    logic [31:0] del_a[$];
    logic [31:0] del_b[$];

    function automatic logic m_ready(input logic sel);
        if (flush) return 1'b0;
        if (sel) return (qb.size() == 0) || out_b_ready;
        return (qa.size() == 0) || out_a_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete(); qb.delete();
            last_a = '0; last_b = '0;
            m_ca = 0; m_cb = 0;
        end else begin
            logic acc;
            acc = in_valid && m_ready(in_sel);
            if (qa.size() != 0 && out_a_ready) begin
                del_a.push_back(qa.pop_front()); m_ca++;
            end
            if (qb.size() != 0 && out_b_ready) begin
                del_b.push_back(qb.pop_front()); m_cb++;
            end
            if (flush) begin
                qa.delete(); qb.delete();
            end else if (acc) begin
                if (in_sel) begin qb.push_back(in_data); last_b = in_data; end
                else        begin qa.push_back(in_data); last_a = in_data; end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; in_sel = 1'b0; in_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_a_ready = 1'b0; out_b_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        rst_n = 1'b1;
        tick();
        total++;
        if ({out_a_valid, out_b_valid, out_a_data, out_b_data, cnt_a, cnt_b} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got va=%b vb=%b da=%h db=%h ca=%h cb=%h want all 0",
                     out_a_valid, out_b_valid, out_a_data, out_b_data, cnt_a, cnt_b);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_single_steer();
        out_b_ready = 1'b1; out_a_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        total++;
        if (out_b_valid !== 1'b1 || out_b_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL steer_b got v=%b d=%h want v=1 d=deadbeef", out_b_valid, out_b_data);
        end
        total++;
        if (out_a_valid !== 1'b0) begin bad++; $display("FAIL steer_a_quiet got=%b want=0", out_a_valid); end
        tick();
        total++;
        if (out_b_valid !== 1'b0 || cnt_b !== 16'd1) begin
            bad++; $display("FAIL steer_done got v=%b cnt=%0d want v=0 cnt=1", out_b_valid, cnt_b);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ca0, cb0;
        ca0 = cnt_a; cb0 = cnt_b;
        out_a_ready = 1'b0; out_b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h11111111;
        tick();
        in_data = 32'h22222222;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_a got=%b want=0", in_ready); end
        tick();
        total++;
        if (out_a_valid !== 1'b1 || out_a_data !== 32'h11111111) begin
            bad++; $display("FAIL bp_a_hold got v=%b d=%h want v=1 d=11111111", out_a_valid, out_a_data);
        end
        in_sel = 1'b1; in_data = 32'h33333333;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_b got=%b want=1", in_ready); end
        tick();
        idle_inputs();
        total++;
        if (out_b_valid !== 1'b1 || out_b_data !== 32'h33333333 || out_a_data !== 32'h11111111) begin
            bad++; $display("FAIL bp_b_pass got vb=%b db=%h da=%h want vb=1 db=33333333 da=11111111",
                            out_b_valid, out_b_data, out_a_data);
        end
        out_a_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h22222222;
        tick();
        idle_inputs();
        total++;
        if (out_a_valid !== 1'b1 || out_a_data !== 32'h22222222) begin
            bad++; $display("FAIL bp_a_second got v=%b d=%h want v=1 d=22222222", out_a_valid, out_a_data);
        end
        tick();
        total++;
        if (out_a_valid !== 1'b0 || cnt_a !== ca0 + 16'd2 || cnt_b !== cb0 + 16'd1) begin
            bad++; $display("FAIL bp_counts got va=%b ca=%0d cb=%0d want va=0 ca=%0d cb=%0d",
                            out_a_valid, cnt_a, cnt_b, ca0 + 16'd2, cb0 + 16'd1);
        end
        total++;
        if (del_a.size() < 2 || del_a[del_a.size()-2] !== 32'h11111111 || del_a[del_a.size()-1] !== 32'h22222222) begin
            bad++; $display("FAIL bp_order got last deliveries not 11111111,22222222 (n=%0d)", del_a.size());
        end
    endtask

    task automatic test_throughput();
        logic [15:0] ca0;
        int gaps;
        ca0 = cnt_a; gaps = 0;
        out_a_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_sel = 1'b0; in_data = 32'(i);
            #1;
            if (in_ready !== 1'b1) gaps++;
            tick();
            if (out_a_valid !== 1'b1 || out_a_data !== 32'(i)) gaps++;
        end
        idle_inputs();
        total++;
        if (gaps != 0) begin bad++; $display("FAIL tput_bubbles got=%0d want=0", gaps); end
        tick();
        total++;
        if (cnt_a !== ca0 + 16'd8 || out_a_valid !== 1'b0) begin
            bad++; $display("FAIL tput_count got ca=%0d v=%b want ca=%0d v=0", cnt_a, out_a_valid, ca0 + 16'd8);
        end
    endtask

    task automatic test_flush();
        logic [15:0] ca0, cb0;
        out_a_ready = 1'b0; out_b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAAAA0000;
        tick();
        ca0 = cnt_a; cb0 = cnt_b;
        total++;
        if (out_a_valid !== 1'b1) begin bad++; $display("FAIL flush_prefill got=%b want=1", out_a_valid); end
        flush = 1'b1; in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h55555555;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
        tick();
        idle_inputs();
        total++;
        if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0 || cnt_a !== ca0 || cnt_b !== cb0) begin
            bad++; $display("FAIL flush_clear got va=%b vb=%b ca=%0d cb=%0d want 0 0 %0d %0d",
                            out_a_valid, out_b_valid, cnt_a, cnt_b, ca0, cb0);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 600; c++) begin
            in_valid    = 1'($urandom_range(0, 1));
            in_sel      = 1'($urandom_range(0, 1));
            in_data     = $urandom;
            out_a_ready = ($urandom_range(0, 3) != 0);
            out_b_ready = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            #1;
            if (in_ready !== m_ready(in_sel)) errs++;
            if (out_a_valid !== (qa.size() != 0) || out_b_valid !== (qb.size() != 0)) errs++;
            if (out_a_data !== (qa.size() != 0 ? qa[0] : last_a)) errs++;
            if (out_b_data !== (qb.size() != 0 ? qb[0] : last_b)) errs++;
            if (cnt_a !== 16'(m_ca) || cnt_b !== 16'(m_cb)) errs++;
            if (errs != 0 && c < 600) begin
                total++; bad++;
                $display("FAIL random_cycle%0d got rdy=%b va=%b da=%h vb=%b db=%h ca=%0d cb=%0d want ca=%0d cb=%0d",
                         c, in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data, cnt_a, cnt_b,
                         16'(m_ca), 16'(m_cb));
                break;
            end
            tick();
        end
        idle_inputs();
        total++;
        if (cnt_a !== 16'(m_ca) || cnt_b !== 16'(m_cb)) begin
            bad++; $display("FAIL random_counts got ca=%0d cb=%0d want ca=%0d cb=%0d", cnt_a, cnt_b, 16'(m_ca), 16'(m_cb));
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [15:0] seen_max;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        out_b_ready = 1'b1; out_a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1;
        n = 0; seen_max = '0;
        while (m_cb < 65536 && n < 70000) begin
            in_data = 32'(n);
            tick();
            if (m_cb == 65535) seen_max = cnt_b;
            n++;
        end
        idle_inputs();
        total++;
        if (m_cb != 65536) begin bad++; $display("FAIL wrap_timeout got deliveries=%0d want=65536", m_cb); end
        total++;
        if (seen_max !== 16'hFFFF) begin bad++; $display("FAIL wrap_max got=%h want=ffff", seen_max); end
        total++;
        if (cnt_b !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h want=0000", cnt_b); end
    endtask

    initial begin
        test_reset();
        test_single_steer();
        test_backpressure();
        test_throughput();
        test_flush();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_demux_32bit_1to2.md
Name: pipe_demux_32bit_1to2

Overview:
- Registered 1-to-2 steering stage: the inverse of the pipeline's 2:1 word selectors.
- Accepts one 32-bit word per cycle over a valid/ready handshake and delivers it to output A (sel=0) or output B (sel=1).
- Each output has a one-entry holding register, so a stall on one output does not block words destined for the other.
- Used between the EX/MEM result path and two independent consumers, e.g. register-file writeback and the HI/LO or store path.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 16, width of the per-output delivered-word counters.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- Flush  input  1  synchronous clear of both holding registers (pipeline squash).
- InValid  input  1  upstream word valid.
- InReady  output  1  stage can accept the word on InData this cycle.
- InData  input  WIDTH  upstream word.
- InSel  input  1  destination: 0 = A, 1 = B.
- OutAValid  output  1  holding register A full.
- OutAReady  input  1  consumer A takes the word.
- OutAData  output  WIDTH  word held for A.
- OutBValid  output  1  holding register B full.
- OutBReady  input  1  consumer B takes the word.
- OutBData  output  WIDTH  word held for B.
- CntA  output  CNT_W  count of words delivered on A, modulo 2^CNT_W.
- CntB  output  CNT_W  count of words delivered on B, modulo 2^CNT_W.

Behaviour:
- Reset (Rst=0, asynchronous): OutAValid=0, OutBValid=0, OutAData=0, OutBData=0, CntA=0, CntB=0. InReady evaluates to 1 while reset is held, but no transfer is taken.
- Per output X, define free_X = !OutXValid | OutXReady. Register X can load in the same cycle it drains.
- InReady is combinational: InSel ? free_B : free_A, forced to 0 while Flush=1. It depends only on InSel and the selected output's state.
- Accept = InValid & InReady. On accept, the selected register loads InData and sets its valid bit next edge. Latency is exactly 1 cycle from accept to OutXValid.
- Delivery on X = OutXValid & OutXReady. If delivery occurs with no new load, OutXValid clears next edge. OutXData holds its last value after drain.
- Simultaneous delivery and load on the same output: the new word replaces the old one and OutXValid stays 1. This gives 1 word/cycle throughput.
- Simultaneous delivery on A and load into B, or the reverse, is independent and legal.
- OutXData and OutXValid are stable while OutXValid=1 and OutXReady=0.
- CntX increments by 1 on each delivery on X and wraps 0xFFFF -> 0x0000. Flush does not change the counters.
- Flush=1: both valid bits clear next edge. Words held at that edge are discarded, not counted, and not delivered. A delivery handshake in the Flush cycle still counts. No accept occurs in that cycle.
- Reset asserted mid-transfer: state clears immediately. After release, the first accept behaves as from power-up.
- Ordering is preserved per output only. Relative order between A and B is not guaranteed.

Test Plan:
- Reset then idle: Rst=0 for 3 cycles, then release -> all outputs 0, InReady=1, CntA=CntB=0.
- Single steer: InData=0xDEADBEEF, InSel=1, InValid for 1 cycle, OutBReady=1 -> OutBValid=1 with 0xDEADBEEF exactly 1 cycle later for 1 cycle; CntB=1; OutAValid stays 0.
- Back-pressure isolation: OutAReady=0, push 0x11111111 to A, then 0x22222222 (A) and 0x33333333 (B) -> A holds 0x11111111 stable; InReady=0 while InSel=0; the B word is accepted and delivered; after OutAReady=1, A delivers 0x11111111 then 0x22222222; CntA=2, CntB=1.
- Full throughput: 8 back-to-back words to A, values 1..8, OutAReady=1 -> delivered 1..8 on consecutive cycles, no bubbles, CntA=8.
- Flush: A full with 0xAAAA0000 and OutAReady=0, pulse Flush with InValid=1 -> OutAValid=0 next cycle, no accept that cycle, CntA unchanged.
- Counter wrap: force 65536 deliveries on B -> CntB returns to 0x0000.
